// File: rtl/counter_seq_master.sv
// Hardware driver for the counter peripheral: loads samples into its RAM, kicks the search, reads the result.
// Latency: N load writes + SETTLE_CYCLES + kick + irq wait + read/capture/ack/done; one bus op per cycle.
// Backpressure: in_ready is high only in LOAD; upstream stalls simply skip a write cycle.
module counter_seq_master #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  num_words,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result_start_pos,
    output logic [15:0] result_length,
    output logic        error,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_KICK, S_WAIT_IRQ,
        S_READ_REQ, S_READ_CAP, S_ACK, S_DONE
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TMO_LIMIT   = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [9:0]  nw_q, nw_d;
    logic [3:0]  settle_q, settle_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] tmo_inc;
    logic        abort_q, abort_d;
    logic        error_q, error_d;
    logic [31:0] res_q, res_d;

    assign tmo_inc          = tmo_q + 32'd1;
    assign error            = error_q;
    assign result_start_pos = res_q[31:16];
    assign result_length    = res_q[15:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            nw_q     <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            abort_q  <= 1'b0;
            error_q  <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nw_q     <= nw_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            abort_q  <= abort_d;
            error_q  <= error_d;
            res_q    <= res_d;
        end
    end

    // Bus strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nw_d         = nw_q;
        settle_d     = settle_q;
        tmo_d        = tmo_q;
        abort_d      = abort_q;
        error_d      = error_q;
        res_d        = res_q;
        in_ready     = 1'b0;
        busy         = (state_q != S_IDLE);
        result_valid = 1'b0;
        m_address    = 2'd0;
        m_chipselect = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_writedata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words != 10'd0 && num_words <= 10'd512) begin
                        error_d = 1'b0;
                        abort_d = 1'b0;
                        idx_d   = 10'd0;
                        nw_d    = num_words;
                        state_d = S_LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_address    = 2'd1;
                    m_writedata  = {6'b0, 1'b1, idx_q[8:0], in_data};
                    idx_d        = idx_q + 10'd1;
                    if (idx_q == nw_q - 10'd1) begin
                        settle_d = 4'd0;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_KICK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_KICK: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 2'd3;
                m_writedata  = 32'h8000_0000;
                tmo_d        = 32'd0;
                state_d      = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                // tmo_q == 0 marks the blanking cycle; a late irq still beats the timeout.
                tmo_d = tmo_inc;
                if (tmo_q != 32'd0 && m_irq) begin
                    state_d = S_READ_REQ;
                end else if (tmo_inc == TMO_LIMIT) begin
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_READ_REQ: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 2'd2;
                state_d      = S_READ_CAP;
            end
            S_READ_CAP: begin
                res_d   = m_readdata;
                state_d = S_ACK;
            end
            S_ACK: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 2'd3;
                m_writedata  = 32'd0;
                state_d      = S_DONE;
            end
            S_DONE: begin
                result_valid = !abort_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_seq_master.sv
// Bench for counter_seq_master: job table plus reset corner case, bus transactions checked via a scoreboard queue.
module tb_counter_seq_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  num_words;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        result_valid;
    logic [15:0] result_start_pos;
    logic [15:0] result_length;
    logic        error;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_irq;

    always #5 clock = ~clock;

    counter_seq_master #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .start(start), .num_words(num_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
        .result_valid(result_valid), .result_start_pos(result_start_pos),
        .result_length(result_length), .error(error), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq)
    );

    // irq_dly: >0 cycles after kick, -1 never (timeout), -2 already high before the job
    typedef struct {
        int          nw;
        bit          stall;
        int          irq_dly;
        logic [15:0] base;
        logic [31:0] rdata;
    } job_t;

    typedef struct {
        bit          rd;
        logic [1:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    job_t        jobs[8];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          kick_cyc, read_cyc, ack_cyc, rv_count;
    int          irq_cd = 0;
    int          irq_dly_cfg = 0;
    logic [31:0] rd_value = 32'd0;
    logic [31:0] exp_res = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_txn(input bit rd, input logic [1:0] a, input logic [31:0] d);
        txn_t t;
        t.rd = rd;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    function automatic logic [15:0] sample(input job_t j, input int i);
        return j.base + 16'(i * 37);
    endfunction

    // Bus monitor and slave model: pops expected transactions, drives irq/readdata.
    initial begin : monitor
        txn_t t;
        m_irq = 1'b0;
        m_readdata = 32'd0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                if (irq_cd > 0) begin
                    irq_cd--;
                    if (irq_cd == 0) m_irq = 1'b1;
                end
                if (m_chipselect) begin
                    chk("bus_one_strobe", 32'(m_read ^ m_write), 32'd1);
                    chk("bus_txn_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        chk("bus_dir_read", 32'(m_read), 32'(t.rd));
                        chk("bus_addr", 32'(m_address), 32'(t.addr));
                        if (!t.rd) chk("bus_wdata", m_writedata, t.data);
                    end
                    if (m_write && m_address == 2'd3 && m_writedata == 32'h8000_0000) begin
                        kick_cyc = cyc;
                        irq_cd = irq_dly_cfg;
                    end
                    if (m_write && m_address == 2'd3 && m_writedata == 32'd0) begin
                        ack_cyc = cyc;
                        m_irq = 1'b0;
                    end
                    if (m_read && m_address == 2'd2) begin
                        read_cyc = cyc;
                        m_readdata = rd_value;
                    end
                end else begin
                    chk("bus_idle_zero", m_writedata | {28'd0, m_read, m_write, m_address}, 32'd0);
                end
                if (result_valid) rv_count++;
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_job(input job_t j, input string tag);
        bit          legal;
        bit          exp_err;
        int          i;
        int          t;
        legal   = (j.nw >= 1 && j.nw <= 512);
        exp_err = !legal || (j.irq_dly == -1);
        rv_count = 0; kick_cyc = 0; read_cyc = 0; ack_cyc = 0;
        irq_dly_cfg = j.irq_dly;
        rd_value = j.rdata;
        if (legal) begin
            for (int k = 0; k < j.nw; k++)
                push_txn(1'b0, 2'd1, {6'b0, 1'b1, 9'(k), sample(j, k)});
            push_txn(1'b0, 2'd3, 32'h8000_0000);
            if (j.irq_dly != -1) push_txn(1'b1, 2'd2, 32'd0);
            push_txn(1'b0, 2'd3, 32'd0);
            if (j.irq_dly != -1) exp_res = j.rdata;
        end
        if (j.irq_dly == -2) m_irq = 1'b1;
        num_words = 10'(j.nw);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (!legal) begin
            @(negedge clock);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_error"}, 32'(error), 32'd1);
            chk({tag, "_result_kept"}, {result_start_pos, result_length}, exp_res);
        end else begin
            i = 0;
            t = 0;
            while (i < j.nw && t < 4 * j.nw + 8) begin
                in_valid = j.stall ? (t % 2 == 0) : 1'b1;
                in_data  = sample(j, i);
                @(negedge clock);
                chk({tag, "_in_ready_load"}, 32'(in_ready & busy), 32'd1);
                @(posedge clock); #1;
                if (in_valid) i++;
                t++;
            end
            in_valid = 1'b0;
            in_data  = 16'd0;
            @(negedge clock);
            chk({tag, "_in_ready_after_last"}, 32'(in_ready), 32'd0);
            t = 0;
            while (busy && t < 2000) begin
                @(negedge clock);
                t++;
            end
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            chk({tag, "_txn_left"}, 32'(exp_q.size()), 32'd0);
            chk({tag, "_error"}, 32'(error), 32'(exp_err));
            chk({tag, "_result_valid_cnt"}, 32'(rv_count), (j.irq_dly == -1) ? 32'd0 : 32'd1);
            chk({tag, "_result"}, {result_start_pos, result_length}, exp_res);
            if (j.irq_dly == -2) chk({tag, "_stale_irq_gap"}, 32'(read_cyc - kick_cyc), 32'd3);
            if (j.irq_dly == -1) chk({tag, "_timeout_gap"}, 32'(ack_cyc - kick_cyc), 32'd21);
        end
        exp_q.delete();
    endtask

    initial begin : main
        job_t rj;
        jobs[0] = '{1,   1'b0, 5,  16'h00AA, 32'h0000_0001};
        jobs[1] = '{512, 1'b1, 3,  16'h1000, 32'h0123_0045};
        jobs[2] = '{0,   1'b0, 5,  16'h0000, 32'h0000_0000};
        jobs[3] = '{513, 1'b0, 5,  16'h0000, 32'h0000_0000};
        jobs[4] = '{3,   1'b0, 5,  16'h2222, 32'h0002_0003};
        jobs[5] = '{4,   1'b0, -1, 16'h3333, 32'hDEAD_BEEF};
        jobs[6] = '{2,   1'b0, -2, 16'h4444, 32'h00FF_0007};
        jobs[7] = '{7,   1'b1, 10, 16'hBEEF, 32'hABCD_1234};

        reset = 1'b1; start = 1'b0; num_words = 10'd0; in_data = 16'd0; in_valid = 1'b0;
        #2;
        chk("reset_ctrl", 32'({busy, in_ready, result_valid, error, m_chipselect, m_read, m_write, m_address}), 32'd0);
        chk("reset_wdata", m_writedata, 32'd0);
        chk("reset_result", {result_start_pos, result_length}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 8; n++) run_job(jobs[n], $sformatf("job%0d", n));

        // Reset in the middle of LOAD while the idx=100 write is on the bus.
        rj = '{200, 1'b0, 5, 16'h5000, 32'h0000_0000};
        for (int k = 0; k < 100; k++) push_txn(1'b0, 2'd1, {6'b0, 1'b1, 9'(k), sample(rj, k)});
        num_words = 10'd200;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_data  = sample(rj, k);
            @(posedge clock); #1;
        end
        in_data = sample(rj, 100);
        #1;
        chk("rst_mid_write_live", m_writedata, {6'b0, 1'b1, 9'd100, sample(rj, 100)});
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({busy, in_ready, result_valid, error, m_chipselect, m_read, m_write, m_address}), 32'd0);
        chk("rst_mid_wdata", m_writedata, 32'd0);
        chk("rst_mid_result", {result_start_pos, result_length}, 32'd0);
        exp_res = 32'd0;
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_txn_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_job('{2, 1'b0, 4, 16'h6060, 32'h0010_0020}, "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_seq_master.md
Name: counter_seq_master

Overview:
- Avalon-MM master that drives the custom counter peripheral's 4-word register map from hardware instead of from NIOS.
- Accepts a stream of 16-bit samples, writes them into the peripheral's RAM, starts the sequence search, waits for the peripheral's IRQ, then reads back the result word and acknowledges the interrupt.
- Sits in the FPGA fabric between a local sample source and the peripheral's slave port, replacing the software driver loop.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between the last RAM write and the start write, covering the peripheral's registered RAM write path. Legal range 1..15.
- TIMEOUT_CYCLES, 65535, maximum cycles spent waiting for m_irq before the job is aborted with error. Counter is 32 bits wide.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- num_words  in  10  number of samples in the job; legal range 1..512.
- in_data  in  16  sample value.
- in_valid  in  1  sample is present on in_data.
- in_ready  out  1  master accepts the sample this cycle.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle pulse when result fields are updated.
- result_start_pos  out  16  readdata[31:16] of the result read.
- result_length  out  16  readdata[15:0] of the result read.
- error  out  1  sticky; set on bad num_words or timeout, cleared by the next accepted start.
- m_address  out  2  peripheral word address.
- m_chipselect  out  1  bus select.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  registered read data; valid the cycle after the read strobe.
- m_irq  in  1  peripheral interrupt, level-sensitive.

Behaviour:
- **Reset values:** all outputs are 0 and the state is IDLE. Reset is asynchronous, so the bus strobes drop immediately, including in the middle of a job; no partial transaction is completed.
- **Bus rules:**
  - Every transaction lasts exactly one cycle, with m_chipselect high together with exactly one of m_read or m_write.
  - When no transaction is active, m_address and m_writedata are 0.
  - There are no wait states, and at most one transaction is issued per cycle.
- **IDLE:**
  - start=1 with num_words in 1..512: clear error and the word index, go to LOAD.
  - start=1 with num_words outside 1..512: set error, stay in IDLE.
  - start is ignored in every other state.
- **LOAD:**
  - in_ready=1.
  - Each cycle with in_valid=1 issues a write to address 1 with writedata = {6'b0, 1'b1, idx[8:0], in_data}, where bit 25 is the write enable and bits 24:16 are the RAM address. idx then increments.
  - When in_valid=0, no transaction is issued.
  - After the write with idx = num_words-1, go to SETTLE. in_ready is 0 from that point on.
- **SETTLE:** wait SETTLE_CYCLES cycles, then go to KICK.
- **KICK:** one write to address 3 with writedata = 32'h8000_0000, then go to WAIT_IRQ and clear the timeout counter.
- **WAIT_IRQ:**
  - m_irq is ignored on the first cycle, as a blanking window.
  - From the second cycle, m_irq=1 goes to READ_REQ.
  - If the counter reaches TIMEOUT_CYCLES, set error and go to ACK with the abort flag set.
  - If m_irq rises on the same cycle the counter expires, the irq wins and the job is not aborted.
- **READ_REQ:** read strobe on address 2, then go to READ_CAP.
- **READ_CAP:** capture m_readdata into the result registers, then go to ACK.
- **ACK:** write to address 3 with writedata = 0. This deasserts the peripheral's start and clears its IRQ. Then go to DONE.
- **DONE:**
  - Normal completion: pulse result_valid for one cycle.
  - Abort: no pulse, and the result registers keep their previous values.
  - Return to IDLE.
- **Latency:** with in_valid held high, a job of N words lasts N + SETTLE_CYCLES + 1 + 1 + irq_wait + 3 cycles of busy.
- **Re-issuing start:** a start in the cycle after DONE (back in IDLE) is accepted.

Test Plan:
- **Single word:** num_words=1, in_data=16'h00AA, slave model raises irq 5 cycles after the start write and returns 32'h0000_0001 → writes 32'h0200_00AA@1, then 32'h8000_0000@3, read @2, then 32'h0@3; result_valid pulses once; start_pos=0, length=1.
- **Full buffer with stalls:** num_words=512, in_valid toggling 1/0 → 512 address-1 writes, with bits 24:16 running 0..511 and no gaps in the index; in_ready drops after index 511; exactly one kick.
- **Illegal counts:** num_words=0, then num_words=513 → error=1 after each, busy stays 0, no bus activity; a following legal start clears error.
- **Timeout:** TIMEOUT_CYCLES=20, irq never asserted → error=1 after 20 wait cycles; ACK write 32'h0@3 is issued; no result_valid; previous result is retained.
- **Stale irq:** m_irq held high before the kick → ignored during the blanking cycle, accepted on the next cycle; ACK clears it.
- **Mid-job reset:** reset asserted during LOAD at idx=100 → strobes drop the same cycle; all outputs are 0; the next job starts from idx=0.
